ps2_scancode_receiver: RTL and testbench
========================================

Name: ps2_scancode_receiver

Overview:
- Receives serial PS/2 keyboard frames from the ps2_clk/ps2_data pins and decodes scan-code set 2 make/break sequences.
- Produces the keyboard_code/makeBreak pair consumed by convert_keyboard_input, plus a one-cycle event strobe.
- Sits between the board PS/2 pins and the keyboard-to-note conversion logic in the top level.

Parameters:
- TIMEOUT_CYCLES, 50000: system clocks without a ps2_clk falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).
- CLEAR_ON_BREAK, 1: when 1, a break of the currently held code drives keyboard_code to 8'h00.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin; asynchronous to clock.
- ps2_data  input  1  raw PS/2 data pin; asynchronous to clock.
- keyboard_code  output  8  last decoded scan code; held between events.
- makeBreak  output  1  1 = key pressed (make), 0 = key released (break); held between events.
- extended  output  1  1 when the last event carried an E0 prefix.
- valid  output  1  one-cycle strobe; keyboard_code, makeBreak and extended update in the same cycle.
- frame_error  output  1  one-cycle strobe on a parity, stop-bit or timeout failure.

Behaviour:
- Reset: asynchronous, active-high; fixed as stated above.
- Reset values: keyboard_code=8'h00, makeBreak=0, extended=0, valid=0, frame_error=0. FSM goes to IDLE; bit counter, shift register, timeout counter and both prefix flags clear.
- Reset asserted mid-frame discards the partial byte; no strobe is issued.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flip-flops. The falling edge is detected as previous synced ps2_clk = 1 and current = 0. All sampling uses synced ps2_data in the edge cycle.
- Frame format: 11 bits, sampled on ps2_clk falling edges: start (0), 8 data bits LSB first, odd parity, stop (1).
- FSM transitions:
  - IDLE -> DATA on an edge with data=0. An edge with data=1 is ignored and the FSM stays in IDLE.
  - DATA shifts 8 bits, LSB first, via a 3-bit counter; it moves to PARITY after bit 7.
  - PARITY stores the sampled bit and moves to STOP.
  - STOP: the edge completes the frame; the FSM always returns to IDLE.
- Frame check on the stop edge: the frame is good if XOR(data[7:0], parity) = 1 and stop = 1. Otherwise frame_error pulses, the byte is dropped and both prefix flags clear.
- Good byte 8'hF0: sets break_pending. No valid.
- Good byte 8'hE0: sets ext_pending. No valid.
- Prefix order: F0 and E0 may arrive in either order (E0 F0 xx is normal); the flags are independent.
- Any other good byte produces an event:
  - valid=1 for exactly one cycle; makeBreak = ~break_pending; extended = ext_pending.
  - keyboard_code = byte, except when break_pending, CLEAR_ON_BREAK=1 and byte equals the currently held keyboard_code; then keyboard_code = 8'h00.
  - Both prefix flags clear in the same cycle.
- Latency: valid is high in the cycle after the synced falling edge of the stop bit is detected. That is 3 clock edges after the pin edge (2 sync + 1 output register).
- Auto-repeat: a repeated make of the same code produces a new valid each time; outputs are unchanged in value.
- Timeout: a counter runs while the FSM is not IDLE and resets on every detected edge. When it reaches TIMEOUT_CYCLES-1, frame_error pulses, the FSM returns to IDLE and both prefix flags clear. The counter does not run in IDLE.
- Simultaneous reset and edge: reset wins.
- valid and frame_error are never high in the same cycle.

Test Plan:
- Make 'A': frame for 8'h1C (parity 0, stop 1) -> one valid pulse; keyboard_code=8'h1C, makeBreak=1, extended=0; exactly 3 clocks after the stop-bit pin edge.
- Break 'A' after make: bytes F0, 1C -> no valid on F0; valid on 1C with makeBreak=0 and keyboard_code=8'h00 (CLEAR_ON_BREAK=1). Repeat with CLEAR_ON_BREAK=0 -> keyboard_code=8'h1C.
- Break of a non-held key: make 1C, then F0 1B -> valid, makeBreak=0, keyboard_code=8'h1B.
- Extended: E0 5A, then E0 F0 5A -> first event extended=1, makeBreak=1, code 8'h5A; second event extended=1, makeBreak=0, code 8'h00.
- Errors:
  - 8'h29 sent with parity 1 -> frame_error pulse, no valid, outputs unchanged.
  - Stop bit 0 -> same response.
  - F0, then a bad frame, then 1C -> valid with makeBreak=1 (prefix discarded).
- Timeout/reset: stop ps2_clk after 5 bits for TIMEOUT_CYCLES clocks -> frame_error pulse; the next full 8'h24 frame decodes correctly. Assert reset mid-frame -> all outputs return to reset values, no strobe.

Source files
------------

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: 2-FF pin sync, 11-bit frame capture, scan-code set 2 F0/E0 prefix decode.
// Latency: valid/frame_error 3 clocks after the stop-bit ps2_clk falling pin edge; timeout aborts stalled frames.
// Backpressure: none; the keyboard cannot be stalled, so each event is a one-cycle strobe with held outputs.
module ps2_scancode_receiver #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit CLEAR_ON_BREAK = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyboard_code,
    output logic       makeBreak,
    output logic       extended,
    output logic       valid,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic          ps2_clk_s1, ps2_clk_s2, ps2_clk_prev;
    logic          ps2_data_s1, ps2_data_s2;
    logic          ps2_fall;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [TW-1:0] timeout_cnt;
    logic          break_pending;
    logic          ext_pending;
    logic          frame_good;

    // Idle PS/2 lines float high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps2_clk_s1   <= 1'b1;
            ps2_clk_s2   <= 1'b1;
            ps2_clk_prev <= 1'b1;
            ps2_data_s1  <= 1'b1;
            ps2_data_s2  <= 1'b1;
        end else begin
            ps2_clk_s1   <= ps2_clk;
            ps2_clk_s2   <= ps2_clk_s1;
            ps2_clk_prev <= ps2_clk_s2;
            ps2_data_s1  <= ps2_data;
            ps2_data_s2  <= ps2_data_s1;
        end
    end

    assign ps2_fall   = ps2_clk_prev & ~ps2_clk_s2;
    assign frame_good = (^{shift_reg, parity_bit}) & ps2_data_s2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            parity_bit    <= 1'b0;
            timeout_cnt   <= '0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            keyboard_code <= 8'h00;
            makeBreak     <= 1'b0;
            extended      <= 1'b0;
            valid         <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            valid       <= 1'b0;
            frame_error <= 1'b0;
            if (state == IDLE) begin
                timeout_cnt <= '0;
                if (ps2_fall && !ps2_data_s2) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
            end else if (ps2_fall) begin
                timeout_cnt <= '0;
                case (state)
                    DATA: begin
                        shift_reg <= {ps2_data_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= ps2_data_s2;
                        state      <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frame_good) begin
                            frame_error   <= 1'b1;
                            break_pending <= 1'b0;
                            ext_pending   <= 1'b0;
                        end else if (shift_reg == 8'hF0) begin
                            break_pending <= 1'b1;
                        end else if (shift_reg == 8'hE0) begin
                            ext_pending <= 1'b1;
                        end else begin
                            valid         <= 1'b1;
                            makeBreak     <= ~break_pending;
                            extended      <= ext_pending;
                            break_pending <= 1'b0;
                            ext_pending   <= 1'b0;
                            // Releasing the held key blanks the code so downstream stops the note.
                            if (break_pending && CLEAR_ON_BREAK && (shift_reg == keyboard_code))
                                keyboard_code <= 8'h00;
                            else
                                keyboard_code <= shift_reg;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout_cnt == TIMEOUT_LAST) begin
                frame_error   <= 1'b1;
                state         <= IDLE;
                timeout_cnt   <= '0;
                break_pending <= 1'b0;
                ext_pending   <= 1'b0;
            end else begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Bench for ps2_scancode_receiver: vector table of PS/2 frames, scoreboard queue of expected strobes.
// Two instances share the pins: one clears the code on break of the held key, one does not.
module tb_ps2_scancode_receiver;

    localparam int TO = 300;
    localparam int H  = 20;
    localparam int EV_NONE = 0;
    localparam int EV_VAL  = 1;
    localparam int EV_ERR  = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code_a, code_b;
    logic       mb_a, mb_b, ext_a, ext_b, val_a, val_b, err_a, err_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stop_cyc = 0;

    typedef struct {
        logic [7:0] dat;
        logic       bad_par;
        logic       stop;
        int         evt;
        logic [7:0] code;
        logic [7:0] code_nc;
        logic       mb;
        logic       ext;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] code;
        logic [7:0] code_nc;
        logic       mb;
        logic       ext;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    ps2_scancode_receiver #(.TIMEOUT_CYCLES(TO), .CLEAR_ON_BREAK(1'b1)) dut_a (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard_code(code_a), .makeBreak(mb_a), .extended(ext_a),
        .valid(val_a), .frame_error(err_a)
    );

    ps2_scancode_receiver #(.TIMEOUT_CYCLES(TO), .CLEAR_ON_BREAK(1'b0)) dut_b (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard_code(code_b), .makeBreak(mb_b), .extended(ext_b),
        .valid(val_b), .frame_error(err_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic bp, input logic st, input int ev,
                                input logic [7:0] c, input logic [7:0] cn, input logic m, input logic e);
        vec_t v;
        v.dat = d; v.bad_par = bp; v.stop = st; v.evt = ev;
        v.code = c; v.code_nc = cn; v.mb = m; v.ext = e;
        return v;
    endfunction

    task automatic push_exp(input logic err, input logic [7:0] c, input logic [7:0] cn,
                            input logic m, input logic e);
        exp_t x;
        x.err = err; x.code = c; x.code_nc = cn; x.mb = m; x.ext = e;
        sb.push_back(x);
    endtask

    task automatic send_bit(input logic b, input logic is_stop);
        @(posedge clock); #1;
        ps2_data = b;
        repeat (H) @(posedge clock);
        #1;
        ps2_clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        repeat (H) @(posedge clock);
        #1;
        ps2_clk = 1'b1;
        repeat (H) @(posedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        logic par;
        par = (~^d) ^ bad_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(par, 1'b0);
        send_bit(stop, 1'b1);
    endtask

    task automatic send_partial(input logic [7:0] d);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    endtask

    // Scoreboard: every strobe from either instance must match the queue head.
    always @(negedge clock) begin
        if (!reset && (val_a || err_a || val_b || err_b)) begin
            chk("valid_and_error_exclusive", {31'd0, val_a & err_a}, 32'd0);
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_strobe: valid=%0b frame_error=%0b with nothing expected", val_a, err_a);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("frame_error", {31'd0, err_a}, {31'd0, x.err});
                chk("valid", {31'd0, val_a}, {31'd0, ~x.err});
                chk("valid_nc", {31'd0, val_b}, {31'd0, ~x.err});
                chk("frame_error_nc", {31'd0, err_b}, {31'd0, x.err});
                chk("keyboard_code", {24'd0, code_a}, {24'd0, x.code});
                chk("keyboard_code_nc", {24'd0, code_b}, {24'd0, x.code_nc});
                chk("makeBreak", {31'd0, mb_a}, {31'd0, x.mb});
                chk("extended", {31'd0, ext_a}, {31'd0, x.ext});
                if (!x.err) chk("latency", cyc - stop_cyc, 32'd3);
            end
        end
    end

    initial begin
        vecs.push_back(mk(8'h1C, 0, 1, EV_VAL,  8'h1C, 8'h1C, 1, 0));
        vecs.push_back(mk(8'hF0, 0, 1, EV_NONE, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(8'h1C, 0, 1, EV_VAL,  8'h00, 8'h1C, 0, 0));
        vecs.push_back(mk(8'h1C, 0, 1, EV_VAL,  8'h1C, 8'h1C, 1, 0));
        vecs.push_back(mk(8'h1C, 0, 1, EV_VAL,  8'h1C, 8'h1C, 1, 0));
        vecs.push_back(mk(8'hF0, 0, 1, EV_NONE, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(8'h1B, 0, 1, EV_VAL,  8'h1B, 8'h1B, 0, 0));
        vecs.push_back(mk(8'hE0, 0, 1, EV_NONE, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(8'h5A, 0, 1, EV_VAL,  8'h5A, 8'h5A, 1, 1));
        vecs.push_back(mk(8'hE0, 0, 1, EV_NONE, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(8'hF0, 0, 1, EV_NONE, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(8'h5A, 0, 1, EV_VAL,  8'h00, 8'h5A, 0, 1));
        vecs.push_back(mk(8'h29, 1, 1, EV_ERR,  8'h00, 8'h5A, 0, 1));
        vecs.push_back(mk(8'h29, 0, 0, EV_ERR,  8'h00, 8'h5A, 0, 1));
        vecs.push_back(mk(8'hF0, 0, 1, EV_NONE, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(8'h29, 1, 1, EV_ERR,  8'h00, 8'h5A, 0, 1));
        vecs.push_back(mk(8'h1C, 0, 1, EV_VAL,  8'h1C, 8'h1C, 1, 0));

        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("reset_code", {24'd0, code_a}, 32'd0);
        chk("reset_makeBreak", {31'd0, mb_a}, 32'd0);
        chk("reset_extended", {31'd0, ext_a}, 32'd0);
        chk("reset_valid", {31'd0, val_a}, 32'd0);
        chk("reset_frame_error", {31'd0, err_a}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (5) @(posedge clock);

        foreach (vecs[i]) begin
            if (vecs[i].evt != EV_NONE)
                push_exp(vecs[i].evt == EV_ERR, vecs[i].code, vecs[i].code_nc, vecs[i].mb, vecs[i].ext);
            send_frame(vecs[i].dat, vecs[i].bad_par, vecs[i].stop);
        end

        // Stalled frame: five bits then silence until the timeout fires.
        push_exp(1'b1, 8'h1C, 8'h1C, 1'b1, 1'b0);
        send_partial(8'h24);
        repeat (TO + 50) @(posedge clock);
        push_exp(1'b0, 8'h24, 8'h24, 1'b1, 1'b0);
        send_frame(8'h24, 1'b0, 1'b1);

        // Reset in the middle of a frame drops it silently.
        send_partial(8'h1C);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_code", {24'd0, code_a}, 32'd0);
        chk("midreset_code_nc", {24'd0, code_b}, 32'd0);
        chk("midreset_makeBreak", {31'd0, mb_a}, 32'd0);
        chk("midreset_extended", {31'd0, ext_a}, 32'd0);
        chk("midreset_valid", {31'd0, val_a}, 32'd0);
        chk("midreset_frame_error", {31'd0, err_a}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (TO + 50) @(posedge clock);
        push_exp(1'b0, 8'h24, 8'h24, 1'b1, 1'b0);
        send_frame(8'h24, 1'b0, 1'b1);

        for (int n = 0; n < 2000 && sb.size() != 0; n++) @(posedge clock);
        repeat (5) @(posedge clock);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
